// File: rtl/activity_stretch.sv
// activity_stretch: turns single-cycle event strobes into human-visible
// pulses of ON_COUNT cycles, each followed by at least OFF_COUNT low cycles.
// Events arriving while a pulse or gap is in progress are queued (up to
// PENDING_MAX) and replayed in order; overflow events are dropped and flagged.
module activity_stretch #(
    parameter int ON_COUNT    = 16,
    parameter int OFF_COUNT   = 16,
    parameter int PENDING_MAX = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic trig,
    output logic out,
    output logic busy,
    output logic drop
);

    localparam int MAXC = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = $clog2(PENDING_MAX + 1);

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_COUNT - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_COUNT - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(PENDING_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;

    // Next-state, counter, pending-queue and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (trig) begin
                    if (pend_q == PEND_MAX) drop_d = 1'b1;
                    else                    pend_d = pend_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d = '0;
                    // A trig on the last gap cycle either replaces the dequeued
                    // entry or is consumed directly, so it can never overflow.
                    if (pend_q != '0) begin
                        state_d = S_ON;
                        if (!trig) pend_d = pend_q - 1'b1;
                    end else if (trig) begin
                        state_d = S_ON;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (trig) begin
                        if (pend_q == PEND_MAX) drop_d = 1'b1;
                        else                    pend_d = pend_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pend_d  = '0;
            end
        endcase

        out_d  = (state_d == S_ON);
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset discards any pulse and queued events.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign drop = drop_q;

endmodule

// File: doc/activity_stretch.md
ACTIVITY_STRETCH -- requirements
Module: activity_stretch

Interface
REQ-001 Parameter ON_COUNT, default 16, number of clock cycles the output is held high per event; legal range >= 1.
REQ-002 Parameter OFF_COUNT, default 16, minimum number of clock cycles the output is held low between two pulses; legal range >= 1.
REQ-003 Parameter PENDING_MAX, default 3, depth of the queued-event counter; legal range >= 1.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 trig  input  1  synchronous event strobe; each high cycle is one event.
REQ-007 out  output  1  stretched, human-visible pulse train; registered.
REQ-008 busy  output  1  high whenever the block is not idle; registered.
REQ-009 drop  output  1  one-cycle strobe when an event is discarded because the queue is full; registered.

Function
REQ-010 The block SHALL implement three states: IDLE, ON, GAP.
REQ-011 Cycle counter width SHALL be ceil(log2(max(ON_COUNT, OFF_COUNT))), minimum 1 bit; pending counter width SHALL be ceil(log2(PENDING_MAX+1)).
REQ-012 IDLE: out=0, busy=0; trig=1 -> next cycle state ON, out=1, busy=1, counter=0 (latency 1 cycle).
REQ-013 ON: counter increments each cycle; at counter==ON_COUNT-1 -> GAP, counter=0, out=0 next cycle; out SHALL be high exactly ON_COUNT cycles per pulse.
REQ-014 GAP: out=0, counter increments each cycle; at counter==OFF_COUNT-1 -> ON (counter=0, out=1) if pending>0 or trig=1, else IDLE; out SHALL be low at least OFF_COUNT cycles between pulses.
REQ-015 trig during ON or GAP (not consumed per REQ-014) SHALL increment pending, saturating at PENDING_MAX.
REQ-016 trig when pending==PENDING_MAX and not consumed SHALL leave pending unchanged and assert drop for exactly one cycle.
REQ-017 GAP end with pending>0 and trig=0: pending decrements by 1.
REQ-018 GAP end with pending>0 and trig=1: pending unchanged (one dequeued, one enqueued), no drop.
REQ-019 GAP end with pending==0 and trig=1: trig consumed directly, pending stays 0, no IDLE cycle inserted.
REQ-020 busy SHALL equal (state != IDLE), registered alongside state.
REQ-021 Every accepted event (not dropped) SHALL produce exactly one ON_COUNT-cycle pulse, in arrival order.
REQ-022 drop SHALL be 0 in all cycles other than those in REQ-016.

Reset
REQ-023 reset_n low SHALL immediately (asynchronously) force state=IDLE, out=0, busy=0, drop=0, counter=0, pending=0.
REQ-024 reset_n asserted mid-ON or mid-GAP SHALL discard the current pulse and all queued events.
REQ-025 After reset_n release, no pulse SHALL be produced until a new trig is sampled high.

Verification (ON_COUNT=4, OFF_COUNT=3, PENDING_MAX=2; trig sampled at cycle 0)
REQ-026 Single trig at cycle 0 -> out=1 cycles 1-4, out=0 cycles 5-7, busy=1 cycles 1-7, busy=0 cycle 8, drop never high.
REQ-027 trig at cycles 0 and 1 -> out=1 cycles 1-4, 0 cycles 5-7, 1 cycles 8-11, 0 cycles 12-14; busy=0 at cycle 15.
REQ-028 trig at cycles 0,1,2,3 -> pending reaches 2, drop=1 at cycle 4 only; exactly three 4-cycle pulses each separated by 3 low cycles.
REQ-029 Single trig at cycle 0, second trig at cycle 7 (last GAP cycle) -> second pulse out=1 cycles 8-11, busy never drops between pulses.
REQ-030 trig at cycles 0 and 1, reset_n low at cycle 2 for 2 cycles -> out=0 and busy=0 immediately on assertion; no further out=1 after release without new trig.
